// File: rtl/mem_port_arbiter.sv
// Two-master req/gnt/rvalid arbiter with an in-order response ID FIFO.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (master 1 wins ties).
module mem_port_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int MAX_OUTST  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    m0_req,
   input  logic [ADDR_WIDTH-1:0]   m0_addr,
   input  logic                    m0_we,
   input  logic [DATA_WIDTH/8-1:0] m0_be,
   input  logic [DATA_WIDTH-1:0]   m0_wdata,
   output logic                    m0_gnt,
   output logic                    m0_rvalid,
   output logic                    m0_err,
   output logic [DATA_WIDTH-1:0]   m0_rdata,
   input  logic                    m1_req,
   input  logic [ADDR_WIDTH-1:0]   m1_addr,
   input  logic                    m1_we,
   input  logic [DATA_WIDTH/8-1:0] m1_be,
   input  logic [DATA_WIDTH-1:0]   m1_wdata,
   output logic                    m1_gnt,
   output logic                    m1_rvalid,
   output logic                    m1_err,
   output logic [DATA_WIDTH-1:0]   m1_rdata,
   output logic                    mem_req,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic                    mem_we,
   output logic [DATA_WIDTH/8-1:0] mem_be,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic                    mem_gnt,
   input  logic                    mem_rvalid,
   input  logic                    mem_err,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic                    err_sticky
);

   localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int CW = $clog2(MAX_OUTST + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTST);
   localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTST - 1);

   logic [MAX_OUTST-1:0] r_ids;
   logic [PW-1:0]        r_wr_ptr;
   logic [PW-1:0]        r_rd_ptr;
   logic [CW-1:0]        r_cnt;
   logic                 r_lock_vld;
   logic                 r_lock_sel;
   logic                 r_err_sticky;
`ifndef MEM_ARB_FIXED_PRIO_EN
   logic                 r_rr_ptr;
`endif

   logic w_both;
   logic w_any;
   logic w_sel;
   logic w_empty;
   logic w_full;
   logic w_req;
   logic w_push;
   logic w_pop;
   logic w_spur;
   logic w_head;

   function automatic logic [PW-1:0] f_next(
      input logic [PW-1:0] p
   );
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   assign w_both = m0_req & m1_req;
   assign w_any  = m0_req | m1_req;

   // A stalled request keeps its master selected until it is granted.
   always_comb begin
      w_sel = m1_req;
      if (r_lock_vld) begin
         w_sel = r_lock_sel;
      end else if (w_both) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
         w_sel = 1'b1;
`else
         w_sel = r_rr_ptr;
`endif
      end
   end

   // A pop in this cycle frees a slot, so a full FIFO can still accept.
   assign w_empty = (r_cnt == '0);
   assign w_full  = (r_cnt == FULL_CNT) & ~mem_rvalid;
   assign w_req   = w_any & ~w_full;
   assign w_push  = w_req & mem_gnt;
   assign w_pop   = mem_rvalid & ~w_empty;
   assign w_spur  = mem_rvalid & w_empty;
   assign w_head  = r_ids[r_rd_ptr];

   assign mem_req   = w_req & ~rst;
   assign mem_addr  = w_sel ? m1_addr  : m0_addr;
   assign mem_we    = w_sel ? m1_we    : m0_we;
   assign mem_be    = w_sel ? m1_be    : m0_be;
   assign mem_wdata = w_sel ? m1_wdata : m0_wdata;

   assign m0_gnt = w_push & ~w_sel & ~rst;
   assign m1_gnt = w_push &  w_sel & ~rst;

   assign m0_rvalid = w_pop & ~w_head & ~rst;
   assign m1_rvalid = w_pop &  w_head & ~rst;
   assign m0_err    = m0_rvalid & mem_err;
   assign m1_err    = m1_rvalid & mem_err;
   assign m0_rdata  = mem_rdata;
   assign m1_rdata  = mem_rdata;

   assign err_sticky = r_err_sticky;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ids        <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_cnt        <= '0;
         r_lock_vld   <= 1'b0;
         r_lock_sel   <= 1'b0;
         r_err_sticky <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
         r_rr_ptr     <= 1'b0;
`endif
      end else begin
         if (w_push) begin
            r_ids[r_wr_ptr] <= w_sel;
            r_wr_ptr        <= f_next(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= f_next(r_rd_ptr);
         end
         if (w_push & ~w_pop) begin
            r_cnt <= r_cnt + CW'(1);
         end else if (~w_push & w_pop) begin
            r_cnt <= r_cnt - CW'(1);
         end
         if (w_spur) begin
            r_err_sticky <= 1'b1;
         end
         if (w_push) begin
            r_lock_vld <= 1'b0;
         end else if (w_req) begin
            r_lock_vld <= 1'b1;
            r_lock_sel <= w_sel;
         end
`ifndef MEM_ARB_FIXED_PRIO_EN
         if (w_push & w_both) begin
            r_rr_ptr <= ~w_sel;
         end
`endif
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized + directed bench for mem_port_arbiter against a queue model.
// Expectations follow MEM_ARB_FIXED_PRIO_EN when it is defined.
module tb_mem_port_arbiter;

   localparam int DW   = 32;
   localparam int AW   = 32;
   localparam int BW   = DW / 8;
   localparam int MAXO = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m1_req;
   logic [AW-1:0] m0_addr, m1_addr;
   logic          m0_we, m1_we;
   logic [BW-1:0] m0_be, m1_be;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic          m0_gnt, m1_gnt;
   logic          m0_rvalid, m1_rvalid;
   logic          m0_err, m1_err;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [BW-1:0] mem_be;
   logic [DW-1:0] mem_wdata;
   logic          mem_gnt;
   logic          mem_rvalid;
   logic          mem_err;
   logic [DW-1:0] mem_rdata;
   logic          err_sticky;

   mem_port_arbiter #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .MAX_OUTST (MAXO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .m0_req    (m0_req),
      .m0_addr   (m0_addr),
      .m0_we     (m0_we),
      .m0_be     (m0_be),
      .m0_wdata  (m0_wdata),
      .m0_gnt    (m0_gnt),
      .m0_rvalid (m0_rvalid),
      .m0_err    (m0_err),
      .m0_rdata  (m0_rdata),
      .m1_req    (m1_req),
      .m1_addr   (m1_addr),
      .m1_we     (m1_we),
      .m1_be     (m1_be),
      .m1_wdata  (m1_wdata),
      .m1_gnt    (m1_gnt),
      .m1_rvalid (m1_rvalid),
      .m1_err    (m1_err),
      .m1_rdata  (m1_rdata),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_gnt   (mem_gnt),
      .mem_rvalid(mem_rvalid),
      .mem_err   (mem_err),
      .mem_rdata (mem_rdata),
      .err_sticky(err_sticky)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model: issuer queue, pending stalled master, tie-break preference.
   int q[$];
   bit lock_v;
   int lock_w;
   int rr;
   bit sticky;

   bit            a_req  [2];
   logic [AW-1:0] a_addr [2];
   bit            a_we   [2];
   logic [BW-1:0] a_be   [2];
   logic [DW-1:0] a_wd   [2];
   bit            g_last [2];

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive();
      m0_req   = a_req[0];
      m0_addr  = a_addr[0];
      m0_we    = a_we[0];
      m0_be    = a_be[0];
      m0_wdata = a_wd[0];
      m1_req   = a_req[1];
      m1_addr  = a_addr[1];
      m1_we    = a_we[1];
      m1_be    = a_be[1];
      m1_wdata = a_wd[1];
   endtask

   task automatic set_m(int i, bit r, logic [AW-1:0] ad, bit we,
                        logic [BW-1:0] be, logic [DW-1:0] wd);
      a_req[i]  = r;
      a_addr[i] = ad;
      a_we[i]   = we;
      a_be[i]   = be;
      a_wd[i]   = wd;
   endtask

   task automatic model_reset();
      q.delete();
      lock_v = 0;
      lock_w = 0;
      rr     = 0;
      sticky = 0;
      g_last = '{0, 0};
   endtask

   task automatic step();
      bit both;
      bit ereq;
      int win;
      bit rv [2];
      drive();
      #3;
      both = a_req[0] && a_req[1];
      ereq = (a_req[0] || a_req[1]) &&
             !(q.size() == MAXO && !mem_rvalid);
      if (lock_v) win = lock_w;
      else if (both) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
         win = 1;
`else
         win = rr;
`endif
      end else win = a_req[1] ? 1 : 0;
      rv = '{0, 0};
      if (mem_rvalid && q.size() > 0) rv[q[0]] = 1;
      chk("mem_req", mem_req, ereq);
      chk("m0_gnt", m0_gnt, ereq && mem_gnt && win == 0);
      chk("m1_gnt", m1_gnt, ereq && mem_gnt && win == 1);
      chk("m0_rvalid", m0_rvalid, rv[0]);
      chk("m1_rvalid", m1_rvalid, rv[1]);
      chk("m0_err", m0_err, rv[0] && mem_err);
      chk("m1_err", m1_err, rv[1] && mem_err);
      if (ereq) begin
         chk("mem_addr", mem_addr, a_addr[win]);
         chk("mem_we", mem_we, a_we[win]);
         chk("mem_be", mem_be, a_be[win]);
         chk("mem_wdata", mem_wdata, a_wd[win]);
      end
      if (rv[0]) chk("m0_rdata", m0_rdata, mem_rdata);
      if (rv[1]) chk("m1_rdata", m1_rdata, mem_rdata);
      g_last = '{0, 0};
      if (mem_rvalid) begin
         if (q.size() > 0) void'(q.pop_front());
         else sticky = 1;
      end
      if (ereq && mem_gnt) begin
         q.push_back(win);
         lock_v = 0;
         if (both) rr = 1 - win;
         g_last[win] = 1;
      end else if (ereq) begin
         lock_v = 1;
         lock_w = win;
      end
      @(posedge clk);
      #1;
      chk("err_sticky", err_sticky, sticky);
   endtask

   task automatic idle_masters();
      a_req[0] = 0;
      a_req[1] = 0;
   endtask

   task automatic drain();
      idle_masters();
      mem_gnt    = 0;
      mem_rvalid = 1;
      for (int k = 0; k < 8 && q.size() > 0; k++) begin
         mem_rdata = $urandom;
         step();
      end
      mem_rvalid = 0;
   endtask

   task automatic chk_zero_outs(string pfx);
      chk({pfx, "_mem_req"}, mem_req, 0);
      chk({pfx, "_m0_gnt"}, m0_gnt, 0);
      chk({pfx, "_m1_gnt"}, m1_gnt, 0);
      chk({pfx, "_m0_rvalid"}, m0_rvalid, 0);
      chk({pfx, "_m1_rvalid"}, m1_rvalid, 0);
      chk({pfx, "_m0_err"}, m0_err, 0);
      chk({pfx, "_m1_err"}, m1_err, 0);
      chk({pfx, "_sticky"}, err_sticky, 0);
   endtask

   initial begin
      rst = 1;
      model_reset();
      for (int i = 0; i < 2; i++) set_m(i, 1, '0, 0, '0, '0);
      mem_gnt    = 1;
      mem_rvalid = 1;
      mem_err    = 1;
      mem_rdata  = '0;
      drive();
      #2;
      chk_zero_outs("reset");
      idle_masters();
      mem_gnt    = 0;
      mem_rvalid = 0;
      mem_err    = 0;
      drive();
      @(posedge clk);
      #1;
      rst = 0;

      // single m0 read
      set_m(0, 1, 32'h10, 0, 4'hF, '0);
      mem_gnt = 1;
      step();
      idle_masters();
      mem_gnt    = 0;
      mem_rvalid = 1;
      mem_rdata  = 32'hCAFE_0001;
      step();
      mem_rvalid = 0;

      // both masters streaming
      mem_gnt = 1;
      for (int c = 0; c < 4; c++) begin
         set_m(0, 1, 32'h100 + c, 0, 4'hF, '0);
         set_m(1, 1, 32'h200 + c, 0, 4'hF, '0);
         mem_rvalid = (q.size() > 0);
         mem_rdata  = 32'hA000 + c;
         step();
      end
      drain();

      // stalled m0 stays selected while m1 arrives
      set_m(0, 1, 32'h40, 0, 4'hF, '0);
      mem_gnt = 0;
      step();
      step();
      set_m(1, 1, 32'h80, 1, 4'h1, 32'h55);
      step();
      mem_gnt = 1;
      step();
      if (g_last[0]) a_req[0] = 0;
      if (g_last[1]) a_req[1] = 0;
      step();
      drain();

      // FIFO full blocks, pop frees a slot in the same cycle
      set_m(0, 1, 32'h300, 0, 4'hF, '0);
      mem_gnt = 1;
      step();
      a_addr[0] = 32'h304;
      step();
      a_addr[0] = 32'h308;
      step();
      mem_rvalid = 1;
      mem_rdata  = 32'h1234;
      step();
      mem_rvalid = 0;
      a_addr[0]  = 32'h30C;
      step();
      drain();

      // m1 write with error response
      set_m(1, 1, 32'h500, 1, 4'b0011, 32'hDEAD_BEEF);
      mem_gnt = 1;
      step();
      idle_masters();
      mem_gnt    = 0;
      mem_rvalid = 1;
      mem_err    = 1;
      mem_rdata  = 32'h0;
      step();
      mem_rvalid = 0;
      mem_err    = 0;

      // randomized traffic
      g_last = '{1, 1};
      repeat (400) begin
         for (int i = 0; i < 2; i++) begin
            if (!a_req[i] || g_last[i]) begin
               set_m(i, $urandom_range(0, 2) != 0, $urandom,
                     1'($urandom_range(0, 1)), 4'($urandom),
                     $urandom);
            end
         end
         mem_gnt    = $urandom_range(0, 3) != 0;
         mem_rvalid = (q.size() > 0) && ($urandom_range(0, 2) != 0);
         mem_err    = $urandom_range(0, 7) == 0;
         mem_rdata  = $urandom;
         step();
      end
      drain();
      mem_err = 0;

      // spurious response
      mem_rvalid = 1;
      step();
      mem_rvalid = 0;

      // async reset in the middle of a burst
      set_m(0, 1, 32'h600, 0, 4'hF, '0);
      set_m(1, 1, 32'h700, 0, 4'hF, '0);
      mem_gnt = 1;
      step();
      mem_rvalid = 1;
      drive();
      #2;
      rst = 1;
      #1;
      chk_zero_outs("midrst");
      @(posedge clk);
      #1;
      rst = 0;
      model_reset();
      idle_masters();
      mem_gnt    = 0;
      mem_rvalid = 1;
      step();
      mem_rvalid = 0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
